store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter XLEN, default 32, data and address width.
REQ-002 Parameter DEPTH, default 4, buffer entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 MemWriteM  input  1  MEM-stage store request.
REQ-006 MemReadM  input  1  MEM-stage load request.
REQ-007 ALUResultM  input  XLEN  MEM-stage byte address.
REQ-008 WriteDataM  input  XLEN  store data.
REQ-009 ByteEnM  input  XLEN/8  store byte enables.
REQ-010 StallSB  output  1  stall the pipeline at or before MEM.
REQ-011 mem_req_valid  output  1  head entry is presented to data memory.
REQ-012 mem_req_addr  output  XLEN  head entry address.
REQ-013 mem_req_data  output  XLEN  head entry data.
REQ-014 mem_req_be  output  XLEN/8  head entry byte enables.
REQ-015 mem_req_ready  input  1  data memory accepts the head entry this cycle.
REQ-016 sb_count  output  $clog2(DEPTH+1)  number of occupied entries.
REQ-017 sb_empty  output  1  high when sb_count == 0.

Function
REQ-018 The block SHALL be a FIFO of {addr, data, be} entries with wr_ptr, rd_ptr and count registers.
REQ-019 Pointers SHALL increment modulo DEPTH and wrap from DEPTH-1 to 0.
REQ-020 Enqueue SHALL occur when MemWriteM=1 and StallSB=0; the entry is written at wr_ptr at the clock edge.
REQ-021 Dequeue SHALL occur when mem_req_valid=1 and mem_req_ready=1; rd_ptr advances at the clock edge.
REQ-022 mem_req_valid SHALL equal (count != 0).
REQ-023 mem_req_addr, mem_req_data and mem_req_be SHALL be driven directly from the entry at rd_ptr.
REQ-024 Enqueue latency: a store into an empty buffer SHALL raise mem_req_valid on the cycle after its enqueue edge.
REQ-025 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-026 Full condition: when count == DEPTH and MemWriteM=1, StallSB SHALL be 1 and no enqueue SHALL occur, even if a dequeue happens in the same cycle.
REQ-027 Load hazard: when MemReadM=1 and any occupied entry satisfies addr[XLEN-1:2] == ALUResultM[XLEN-1:2], StallSB SHALL be 1.
REQ-028 Load hazard stall SHALL persist until no occupied entry matches.
REQ-029 StallSB SHALL be combinational from the inputs and the current state, and SHALL be 0 in every other case.
REQ-030 mem_req_valid=1 with mem_req_ready=0 SHALL hold all mem_req_* outputs stable.
REQ-031 Addresses SHALL be stored unmodified; no alignment checking is performed.
REQ-032 MemWriteM and MemReadM both high SHALL be treated as a store; hazard checking applies only when MemWriteM=0.
REQ-033 count SHALL never exceed DEPTH and never underflow.

Reset
REQ-034 While rst=1 at a clock edge, wr_ptr, rd_ptr and count SHALL be set to 0.
REQ-035 While rst=1, all entry contents SHALL be discarded, including a store presented in the same cycle.
REQ-036 After reset: mem_req_valid=0, sb_empty=1, sb_count=0, StallSB=0.
REQ-037 Entry data arrays need not be reset; mem_req_addr, mem_req_data and mem_req_be are don't-care while mem_req_valid=0.
REQ-038 Reset asserted mid-drain SHALL drop all pending entries, with mem_req_valid=0 on the cycle after the reset edge.

Verification
REQ-039 mem_req_ready=1 and a store of 7 to address 96 (be=0xF) -> next cycle mem_req_valid=1, addr=96, data=7, be=0xF; the cycle after that, sb_empty=1.
REQ-040 mem_req_ready=0 and 5 back-to-back stores to addresses 0, 4, 8, 12, 16 -> first four enqueued, sb_count=4, StallSB=1 on the fifth; raise mem_req_ready -> drained in order 0, 4, 8, 12, then 16 enqueued.
REQ-041 mem_req_ready=0, store 25 to address 100, then load from address 102 -> StallSB=1; one ready cycle -> StallSB=0 on the following cycle.
REQ-042 mem_req_ready=0, store to address 100, then load from address 104 -> StallSB=0, no stall.
REQ-043 Continuous store with mem_req_ready=1 for 2*DEPTH+3 cycles -> pointers wrap, sb_count stays at 1, data emerges in order with 1-cycle latency.
REQ-044 Three entries buffered, then rst=1 for one cycle -> sb_count=0 and mem_req_valid=0 afterward, and the dropped entries never appear on mem_req_*.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer sitting between the MEM stage and data memory.
// Stores are queued as {addr, data, be} entries and handed to memory in
// program order. The head entry is presented directly on mem_req_*. The
// pipeline is stalled when a store meets a full buffer, or when a load hits
// a word that still has a pending store in the buffer.
module store_buffer #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         MemWriteM,
   input  logic                         MemReadM,
   input  logic [XLEN-1:0]              ALUResultM,
   input  logic [XLEN-1:0]              WriteDataM,
   input  logic [XLEN/8-1:0]            ByteEnM,
   output logic                         StallSB,
   output logic                         mem_req_valid,
   output logic [XLEN-1:0]              mem_req_addr,
   output logic [XLEN-1:0]              mem_req_data,
   output logic [XLEN/8-1:0]            mem_req_be,
   input  logic                         mem_req_ready,
   output logic [$clog2(DEPTH+1)-1:0]   sb_count,
   output logic                         sb_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int BE_W  = XLEN/8;

   logic [XLEN-1:0]  addr_q [DEPTH];
   logic [XLEN-1:0]  data_q [DEPTH];
   logic [BE_W-1:0]  be_q   [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;

   logic             full;
   logic             hazard;
   logic             enq;
   logic             deq;
   logic [PTR_W-1:0] slot;

   // Pointers wrap explicitly from the last entry back to entry 0.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH-1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   assign full = (count == CNT_W'(DEPTH));

   // Scan every occupied entry (offsets 0..count-1 from the head) for a word-address match with the load.
   always_comb begin
      hazard = 1'b0;
      slot   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot = rd_ptr + PTR_W'(i);
         if ((CNT_W'(i) < count) &&
             (addr_q[slot][XLEN-1:2] == ALUResultM[XLEN-1:2])) begin
            hazard = 1'b1;
         end
      end
   end

   // A store (even with MemReadM also high) only stalls on full; a pure load stalls on a pending match.
   always_comb begin
      StallSB = 1'b0;
      if (MemWriteM) begin
         StallSB = full;
      end else if (MemReadM) begin
         StallSB = hazard;
      end
   end

   assign enq = MemWriteM & ~StallSB;
   assign deq = (count != '0) & mem_req_ready;

   // Pointer and occupancy bookkeeping; reset empties the buffer regardless of other activity.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (deq) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({enq, deq})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage is not reset; a store presented during reset is simply not written.
   always_ff @(posedge clk) begin
      if (!rst && enq) begin
         addr_q[wr_ptr] <= ALUResultM;
         data_q[wr_ptr] <= WriteDataM;
         be_q[wr_ptr]   <= ByteEnM;
      end
   end

   assign mem_req_valid = (count != '0);
   assign mem_req_addr  = addr_q[rd_ptr];
   assign mem_req_data  = data_q[rd_ptr];
   assign mem_req_be    = be_q[rd_ptr];
   assign sb_count      = count;
   assign sb_empty      = (count == '0);

endmodule
